// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack backing-memory port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_dm #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int INDEX_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] dato_i,
    input  logic              memwrite_i,
    input  logic              memread_i,
    output logic [DATA_W-1:0] dato_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_dato_o,
    input  logic [DATA_W-1:0] mem_dato_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    // state  | meaning
    // IDLE   | serve read hits combinationally, launch misses and writes
    // REFILL | backing read in flight; ack data bypasses to the core and fills the line
    // WRITE  | backing write in flight; ack updates the line only on a hit

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q [LINES];
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINES-1:0]    valid_q;

    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                fill_en;
    logic                wr_en;

    assign index = addr_i[INDEX_W-1:0];
    assign tag   = addr_i[ADDR_W-1:INDEX_W];
    assign hit   = valid_q[index] && (tag_q[index] == tag);

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        dato_o     = '0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_dato_o = '0;
        fill_en    = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (memwrite_i) begin
                    stall_o = 1'b1;
                    state_d = WRITE;
                end else if (memread_i) begin
                    if (hit) begin
                        dato_o = data_q[index];
                    end else begin
                        stall_o = 1'b1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = addr_i;
                if (mem_ack_i) begin
                    dato_o  = memread_i ? mem_dato_i : '0;
                    fill_en = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            WRITE: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = addr_i;
                mem_dato_o = dato_i;
                if (mem_ack_i) begin
                    wr_en   = hit;
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_en) valid_q[index] <= 1'b1;
        end
    end

    // Line payload is never reset; a reset-cycle ack must not touch it either.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill_en) begin
                data_q[index] <= mem_dato_i;
                tag_q[index]  <= tag;
            end else if (wr_en) begin
                data_q[index] <= dato_i;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && !memwrite_i && memread_i && hit && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && state_d == REFILL && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: vector table for the read path, hand sequences for writes and reset abort.
module tb_dcache_dm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [5:0]  addr_i;
    logic [31:0] dato_i;
    logic        memwrite_i;
    logic        memread_i;
    logic [31:0] dato_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [5:0]  mem_addr_o;
    logic [31:0] mem_dato_o;
    logic [31:0] mem_dato_i;
    logic        mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    dcache_dm #(.DATA_W(32), .ADDR_W(6), .INDEX_W(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .addr_i     (addr_i),
        .dato_i     (dato_i),
        .memwrite_i (memwrite_i),
        .memread_i  (memread_i),
        .dato_o     (dato_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_dato_o (mem_dato_o),
        .mem_dato_i (mem_dato_i),
        .mem_ack_i  (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst, rd, wr;
        logic [5:0]  addr;
        logic [31:0] din, mdat;
        logic        ack;
        logic        e_stall, e_req, e_we;
        logic [5:0]  e_maddr;
        logic [31:0] e_mdato, e_dato;
    } vec_t;

    vec_t tbl[14];

    // Inputs change just after the falling edge; outputs are checked 1ns later, well before the rising edge.
    task automatic step(input logic rst, input logic rd, input logic wr, input logic [5:0] addr,
                        input logic [31:0] din, input logic [31:0] mdat, input logic ack);
        @(negedge clk_i);
        rst_i = rst; memread_i = rd; memwrite_i = wr; addr_i = addr;
        dato_i = din; mem_dato_i = mdat; mem_ack_i = ack;
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk(input string tag, input logic e_stall, input logic e_req, input logic e_we,
                       input logic [5:0] e_maddr, input logic [31:0] e_mdato, input logic [31:0] e_dato);
        cmp({tag, ".stall"},    {31'd0, stall_o},   {31'd0, e_stall});
        cmp({tag, ".req"},      {31'd0, mem_req_o}, {31'd0, e_req});
        cmp({tag, ".we"},       {31'd0, mem_we_o},  {31'd0, e_we});
        cmp({tag, ".mem_addr"}, {26'd0, mem_addr_o}, {26'd0, e_maddr});
        cmp({tag, ".mem_dato"}, mem_dato_o, e_mdato);
        cmp({tag, ".dato"},     dato_o, e_dato);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst  rd   wr   addr   din  mdat           ack  stall req  we  maddr  mdato dato
        tbl[0]  = '{1'b1,1'b0,1'b0,6'h00,32'h0,32'h0,          1'b0,1'b0,1'b0,1'b0,6'h00,32'h0,32'h0};
        tbl[1]  = '{1'b1,1'b0,1'b0,6'h00,32'h0,32'h0,          1'b0,1'b0,1'b0,1'b0,6'h00,32'h0,32'h0};
        tbl[2]  = '{1'b0,1'b0,1'b0,6'h00,32'h0,32'h0,          1'b0,1'b0,1'b0,1'b0,6'h00,32'h0,32'h0};
        tbl[3]  = '{1'b0,1'b1,1'b0,6'h05,32'h0,32'h0,          1'b0,1'b1,1'b0,1'b0,6'h00,32'h0,32'h0};
        tbl[4]  = '{1'b0,1'b1,1'b0,6'h05,32'h0,32'h0,          1'b0,1'b1,1'b1,1'b0,6'h05,32'h0,32'h0};
        tbl[5]  = '{1'b0,1'b1,1'b0,6'h05,32'h0,32'hDEADBEEF,   1'b1,1'b0,1'b1,1'b0,6'h05,32'h0,32'hDEADBEEF};
        tbl[6]  = '{1'b0,1'b1,1'b0,6'h05,32'h0,32'h0,          1'b0,1'b0,1'b0,1'b0,6'h00,32'h0,32'hDEADBEEF};
        tbl[7]  = '{1'b0,1'b1,1'b0,6'h15,32'h0,32'h0,          1'b0,1'b1,1'b0,1'b0,6'h00,32'h0,32'h0};
        tbl[8]  = '{1'b0,1'b1,1'b0,6'h15,32'h0,32'hCAFE0015,   1'b1,1'b0,1'b1,1'b0,6'h15,32'h0,32'hCAFE0015};
        tbl[9]  = '{1'b0,1'b1,1'b0,6'h15,32'h0,32'h0,          1'b0,1'b0,1'b0,1'b0,6'h00,32'h0,32'hCAFE0015};
        tbl[10] = '{1'b0,1'b1,1'b0,6'h05,32'h0,32'h0,          1'b0,1'b1,1'b0,1'b0,6'h00,32'h0,32'h0};
        tbl[11] = '{1'b0,1'b1,1'b0,6'h05,32'h0,32'hDEADBEEF,   1'b1,1'b0,1'b1,1'b0,6'h05,32'h0,32'hDEADBEEF};
        tbl[12] = '{1'b0,1'b1,1'b0,6'h05,32'h0,32'h0,          1'b0,1'b0,1'b0,1'b0,6'h00,32'h0,32'hDEADBEEF};
        tbl[13] = '{1'b0,1'b0,1'b0,6'h05,32'h0,32'hFFFFFFFF,   1'b1,1'b0,1'b0,1'b0,6'h00,32'h0,32'h0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].mdat, tbl[i].ack);
            chk($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_req, tbl[i].e_we,
                tbl[i].e_maddr, tbl[i].e_mdato, tbl[i].e_dato);
        end

        // Write hit to 6'h05, ack withheld three cycles; read and write both asserted, write wins.
        step(0, 1, 1, 6'h05, 32'h12345678, 32'h0, 0);
        chk("wr_hit_launch", 1, 0, 0, 6'h00, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 6'h05, 32'h12345678, 32'h0, 0);
            chk($sformatf("wr_hit_wait%0d", i), 1, 1, 1, 6'h05, 32'h12345678, 32'h0);
        end
        step(0, 1, 1, 6'h05, 32'h12345678, 32'h0, 1);
        chk("wr_hit_ack", 0, 1, 1, 6'h05, 32'h12345678, 32'h0);
        step(0, 1, 0, 6'h05, 32'h0, 32'h0, 0);
        chk("rd_after_wr_hit", 0, 0, 0, 6'h00, 32'h0, 32'h12345678);

        // Write miss to 6'h22 must not allocate.
        step(0, 0, 1, 6'h22, 32'hA5A5A5A5, 32'h0, 0);
        chk("wr_miss_launch", 1, 0, 0, 6'h00, 32'h0, 32'h0);
        step(0, 0, 1, 6'h22, 32'hA5A5A5A5, 32'h0, 1);
        chk("wr_miss_ack", 0, 1, 1, 6'h22, 32'hA5A5A5A5, 32'h0);
        step(0, 1, 0, 6'h22, 32'h0, 32'h0, 0);
        chk("rd_after_wr_miss", 1, 0, 0, 6'h00, 32'h0, 32'h0);
        step(0, 1, 0, 6'h22, 32'h0, 32'h0BADF00D, 1);
        chk("refill_22", 0, 1, 0, 6'h22, 32'h0, 32'h0BADF00D);
        step(0, 1, 0, 6'h22, 32'h0, 32'h0, 0);
        chk("hit_22", 0, 0, 0, 6'h00, 32'h0, 32'h0BADF00D);

        // Reset while a refill of 6'h0A is outstanding.
        step(0, 1, 0, 6'h05, 32'h0, 32'h0, 0);
        chk("hit_05_pre_abort", 0, 0, 0, 6'h00, 32'h0, 32'h12345678);
        step(0, 1, 0, 6'h0A, 32'h0, 32'h0, 0);
        chk("miss_0a", 1, 0, 0, 6'h00, 32'h0, 32'h0);
        step(0, 1, 0, 6'h0A, 32'h0, 32'h0, 0);
        chk("refill_0a_wait", 1, 1, 0, 6'h0A, 32'h0, 32'h0);
        step(1, 1, 0, 6'h0A, 32'h0, 32'h0, 0);
        step(0, 0, 0, 6'h0A, 32'h0, 32'h77777777, 1);
        chk("late_ack_ignored", 0, 0, 0, 6'h00, 32'h0, 32'h0);
        step(0, 1, 0, 6'h05, 32'h0, 32'h0, 0);
        chk("post_rst_miss_05", 1, 0, 0, 6'h00, 32'h0, 32'h0);
        step(0, 1, 0, 6'h05, 32'h0, 32'h12345678, 1);
        chk("post_rst_refill_05", 0, 1, 0, 6'h05, 32'h0, 32'h12345678);

`ifdef DCACHE_STATS_EN
        step(1, 0, 0, 6'h00, 32'h0, 32'h0, 0);
        step(0, 0, 0, 6'h00, 32'h0, 32'h0, 0);
        cmp("hit_cnt_rst0", hit_cnt_o, 32'd0);
        cmp("miss_cnt_rst0", miss_cnt_o, 32'd0);
        step(0, 1, 0, 6'h05, 32'h0, 32'h0, 0);
        step(0, 1, 0, 6'h05, 32'h0, 32'h11111111, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 6'h05, 32'h0, 32'h0, 0);
        step(0, 1, 0, 6'h15, 32'h0, 32'h0, 0);
        step(0, 1, 0, 6'h15, 32'h0, 32'h22222222, 1);
        step(0, 0, 0, 6'h00, 32'h0, 32'h0, 0);
        cmp("hit_cnt", hit_cnt_o, 32'd3);
        cmp("miss_cnt", miss_cnt_o, 32'd2);
        step(1, 0, 0, 6'h00, 32'h0, 32'h0, 0);
        step(0, 0, 0, 6'h00, 32'h0, 32'h0, 0);
        cmp("hit_cnt_rst1", hit_cnt_o, 32'd0);
        cmp("miss_cnt_rst1", miss_cnt_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
Parametrised direct-mapped, write-through, no-write-allocate data cache for the single-cycle datapath. It replaces the flat data array with a tagged line store in front of a slower backing memory, reached through a req/ack handshake. The block stalls the core through stall_o during misses and writes. It sits between the core's load/store port and the data backing memory.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 6, word-address width from the core
INDEX_W, 4, line index width; 2**INDEX_W one-word lines; tag width = ADDR_W-INDEX_W (must be >=1)

Ports:
clk_i  in  1  single clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
addr_i  in  ADDR_W  word address from core
dato_i  in  DATA_W  store data
memwrite_i  in  1  store request
memread_i  in  1  load request
dato_o  out  DATA_W  load data; 0 when memread_i=0
stall_o  out  1  core must hold addr_i/dato_i/memread_i/memwrite_i and not advance
mem_req_o  out  1  backing-memory request
mem_we_o  out  1  1=write, 0=read; valid while mem_req_o=1
mem_addr_o  out  ADDR_W  backing-memory word address
mem_dato_o  out  DATA_W  backing-memory write data
mem_dato_i  in  DATA_W  backing-memory read data; valid when mem_ack_i=1
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Storage: data[2**INDEX_W], tag[2**INDEX_W], valid[2**INDEX_W]. index = addr_i[INDEX_W-1:0], tag = addr_i[ADDR_W-1:INDEX_W].
- hit = valid[index] && tag[index]==tag(addr_i).
- FSM states: IDLE, REFILL, WRITE.
- IDLE, memwrite_i=1: stall_o=1 combinationally; next state WRITE. memwrite_i takes priority over memread_i; dato_o=0 when both are set.
- IDLE, memread_i=1, hit: dato_o=data[index] combinationally, stall_o=0, stay in IDLE (zero-latency hit).
- IDLE, memread_i=1, miss: stall_o=1; next state REFILL.
- REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o=addr_i.
  - No ack: stall_o=1.
  - Ack cycle: dato_o=mem_dato_i (bypass), stall_o=0. At the edge, write the line data, tag and valid=1, then return to IDLE.
- WRITE: mem_req_o=1, mem_we_o=1, mem_addr_o=addr_i, mem_dato_o=dato_i.
  - No ack: stall_o=1.
  - Ack cycle: stall_o=0. At the edge, if hit, update data[index]; a miss does not allocate. Return to IDLE.
- Minimum latency: read miss 2 cycles, write 2 cycles, with ack arriving on the first request cycle. Ack may arrive any number of cycles later.
- Outside REFILL/WRITE: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_dato_o=0. mem_ack_i is ignored in IDLE.
- Reset: state=IDLE and all valid bits cleared in the same edge; data/tag arrays are not cleared. In reset, while held and in the IDLE cycle that follows: stall_o=0, mem_req_o=0, mem_we_o=0, dato_o=0 unless a hit, which cannot occur since valid is clear.
- Reset mid-REFILL/WRITE aborts: mem_req_o drops on the cycle after the reset edge, no line is updated, and a late ack is ignored.

Optional Feature:
DCACHE_STATS_EN: when defined, adds ports hit_cnt_o and miss_cnt_o, out, 32 bits each.
- hit_cnt_o increments once per IDLE read hit.
- miss_cnt_o increments once per REFILL entry.
- Both saturate at 32'hFFFFFFFF and clear on rst_i.
When undefined, neither the ports nor the counters exist.

Test Plan:
- Reset, then memread_i=1, addr_i=6'h05: expect stall_o=1. Next cycle mem_req_o=1, mem_addr_o=6'h05. Ack with mem_dato_i=32'hDEADBEEF -> dato_o=32'hDEADBEEF and stall_o=0 in the ack cycle. Re-read 6'h05 -> hit in the same cycle, no mem_req_o.
- Conflict: after filling 6'h05, read 6'h15 (same index 5, tag 1): expect a miss and refill. Then read 6'h05: miss again.
- Write hit: 6'h05 cached, memwrite_i=1, dato_i=32'h12345678. Expect mem_we_o=1 and mem_dato_o=32'h12345678; ack after 3 cycles. Read 6'h05 -> hit returning 32'h12345678.
- Write miss to 6'h22: backing write occurs, then read 6'h22 -> miss (no allocate).
- Assert rst_i while in REFILL with ack withheld: mem_req_o=0 the next cycle, a late ack causes no change, a previously cached address now misses.
- DCACHE_STATS_EN defined: 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2; after rst_i both read 0.
